// File: rtl/synth_poly_core.sv
// synth_poly_core -- polyphonic oscillator core with 1-bit sigma-delta output.
//
// NUM_VOICES independent voices are configured through a write-only SPI port
// and started together by a shared trigger. Each active voice produces a
// square or saw sample. The samples are summed, optionally muted, and turned
// into a first-order sigma-delta bit stream that drives an external RC filter.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   trig         in   async note trigger, rising edge starts enabled voices
//   spi_clk      in   SPI clock (mode 0), async to clk, f_clk >= 4 x f_spi_clk
//   spi_mosi     in   SPI data, MSB first
//   spi_nss      in   SPI chip select, active low
//   data         out  sigma-delta output bit
//   voice_active out  per-voice sounding flags
//   spi_miso     out  register readback data (only with SYNTH_SPI_READBACK_EN)
//
// Optional feature macro: SYNTH_SPI_READBACK_EN adds spi_miso and read frames.
// Without it, frames with bit15 = 1 are discarded.

module synth_poly_core #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int AMP_W      = 8,
    parameter int DUR_W      = 16,
    parameter int TICK_DIV   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_nss,
    output logic                  data,
    output logic [NUM_VOICES-1:0] voice_active
`ifdef SYNTH_SPI_READBACK_EN
    ,
    output logic                  spi_miso
`endif
);

    localparam int SW = AMP_W + $clog2(NUM_VOICES);

    // Bit positions inside the synchroniser vectors
    localparam int I_TRIG = 0;
    localparam int I_SCK  = 1;
    localparam int I_MOSI = 2;
    localparam int I_NSS  = 3;

    logic [3:0] sync1_q, sync2_q, prev_q;
    logic       trig_rise_q, sck_rise_q, nss_rise_q, nss_fall_q;
`ifdef SYNTH_SPI_READBACK_EN
    logic       sck_fall_q;
`endif

    // Two-flop synchronisers plus registered single-cycle edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 4'b0000;
            sync2_q     <= 4'b0000;
            prev_q      <= 4'b0000;
            trig_rise_q <= 1'b0;
            sck_rise_q  <= 1'b0;
            nss_rise_q  <= 1'b0;
            nss_fall_q  <= 1'b0;
        end else begin
            sync1_q     <= {spi_nss, spi_mosi, spi_clk, trig};
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            trig_rise_q <= sync2_q[I_TRIG] & ~prev_q[I_TRIG];
            sck_rise_q  <= sync2_q[I_SCK] & ~prev_q[I_SCK];
            nss_rise_q  <= sync2_q[I_NSS] & ~prev_q[I_NSS];
            nss_fall_q  <= ~sync2_q[I_NSS] & prev_q[I_NSS];
        end
    end

`ifdef SYNTH_SPI_READBACK_EN
    // Falling spi_clk pulse, only needed to drive readback data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_fall_q <= 1'b0;
        end else begin
            sck_fall_q <= ~sync2_q[I_SCK] & prev_q[I_SCK];
        end
    end
`endif

    logic [15:0] shift_q;
    logic [4:0]  bitcnt_q;
    logic        wr_en_s;
    logic [6:0]  wr_addr_s;
    logic [7:0]  wr_data_s;

    // SPI shifter; prev_q holds the values aligned with the registered pulses.
    // The bit counter saturates so long frames can never wrap back to 16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= 16'h0000;
            bitcnt_q <= 5'd0;
        end else if (nss_fall_q) begin
            bitcnt_q <= 5'd0;
        end else if (sck_rise_q && !prev_q[I_NSS]) begin
            shift_q <= {shift_q[14:0], prev_q[I_MOSI]};
            if (bitcnt_q != 5'd31) begin
                bitcnt_q <= bitcnt_q + 5'd1;
            end
        end
    end

    // Only complete 16-bit write frames commit
    assign wr_en_s   = nss_rise_q && (bitcnt_q == 5'd16) && !shift_q[15];
    assign wr_addr_s = shift_q[14:8];
    assign wr_data_s = shift_q[7:0];

    logic [PHASE_W-1:0]    freq_q [NUM_VOICES];
    logic [AMP_W-1:0]      amp_q  [NUM_VOICES];
    logic [DUR_W-1:0]      dur_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q, wave_q;
    logic                  mute_q;

    // Register file; the mute address is decoded first because it aliases
    // the reserved slot of voice 15
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_q[v] <= '0;
                amp_q[v]  <= '0;
                dur_q[v]  <= '0;
            end
            en_q   <= '0;
            wave_q <= '0;
            mute_q <= 1'b0;
        end else if (wr_en_s) begin
            if (wr_addr_s == 7'h7F) begin
                mute_q <= wr_data_s[0];
            end else begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (wr_addr_s[6:3] == 4'(v)) begin
                        case (wr_addr_s[2:0])
                            3'd0: freq_q[v][7:0]  <= wr_data_s;
                            3'd1: freq_q[v][15:8] <= wr_data_s;
                            3'd2: amp_q[v]        <= wr_data_s;
                            3'd3: dur_q[v][7:0]   <= wr_data_s;
                            3'd4: dur_q[v][15:8]  <= wr_data_s;
                            3'd5: begin
                                en_q[v]   <= wr_data_s[0];
                                wave_q[v] <= wr_data_s[1];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    logic [TICK_DIV-1:0]   presc_q;
    logic                  tick_s;
    logic [DUR_W-1:0]      cnt_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q;

    assign tick_s = &presc_q;

    // Voice state: trigger beats disable beats duration tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            active_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                cnt_q[v]   <= '0;
                phase_q[v] <= '0;
            end
        end else begin
            presc_q <= presc_q + TICK_DIV'(1);
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (trig_rise_q && en_q[v] && (dur_q[v] != '0)) begin
                    cnt_q[v]    <= dur_q[v];
                    phase_q[v]  <= '0;
                    active_q[v] <= 1'b1;
                end else if (active_q[v]) begin
                    phase_q[v] <= phase_q[v] + freq_q[v];
                    if (!en_q[v]) begin
                        active_q[v] <= 1'b0;
                    end else if (tick_s) begin
                        cnt_q[v] <= cnt_q[v] - DUR_W'(1);
                        if (cnt_q[v] == DUR_W'(1)) begin
                            active_q[v] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    logic [AMP_W-1:0] sample_q [NUM_VOICES];

    // Per-voice sample; saw scales the top phase bits by the amplitude
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                sample_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (!active_q[v]) begin
                    sample_q[v] <= '0;
                end else if (wave_q[v]) begin
                    sample_q[v] <= AMP_W'(({{AMP_W{1'b0}}, phase_q[v][PHASE_W-1 -: AMP_W]} *
                                           {{AMP_W{1'b0}}, amp_q[v]}) >> AMP_W);
                end else if (!phase_q[v][PHASE_W-1]) begin
                    sample_q[v] <= amp_q[v];
                end else begin
                    sample_q[v] <= '0;
                end
            end
        end
    end

    logic [SW-1:0] mix_s, sum_q, acc_q;
    logic          data_q;

    // Mixer: SW is wide enough that the full-scale sum cannot overflow
    always_comb begin
        mix_s = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_s = mix_s + SW'(sample_q[v]);
        end
    end

    // Mute gate and first-order sigma-delta; the carry out is the output bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            acc_q  <= '0;
            data_q <= 1'b0;
        end else begin
            sum_q           <= mute_q ? '0 : mix_s;
            {data_q, acc_q} <= {1'b0, acc_q} + {1'b0, sum_q};
        end
    end

    assign data         = data_q;
    assign voice_active = active_q;

`ifdef SYNTH_SPI_READBACK_EN
    // Register readback value; unmapped addresses read as zero
    function automatic logic [7:0] rd_reg(input logic [6:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a == 7'h7F) begin
            r = {7'b0000000, mute_q};
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (a[6:3] == 4'(v)) begin
                    case (a[2:0])
                        3'd0:    r = freq_q[v][7:0];
                        3'd1:    r = freq_q[v][15:8];
                        3'd2:    r = amp_q[v];
                        3'd3:    r = dur_q[v][7:0];
                        3'd4:    r = dur_q[v][15:8];
                        3'd5:    r = {6'b000000, wave_q[v], en_q[v]};
                        default: r = 8'h00;
                    endcase
                end
            end
        end
        return r;
    endfunction

    logic [7:0] rd_val_s;
    logic [7:0] miso_sh_q;
    logic       miso_q, rd_q;

    assign rd_val_s = rd_reg(shift_q[6:0]);

    // After 8 bits the header is complete; stream the register out on falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_q    <= 1'b0;
            rd_q      <= 1'b0;
            miso_sh_q <= 8'h00;
        end else if (prev_q[I_NSS]) begin
            miso_q <= 1'b0;
            rd_q   <= 1'b0;
        end else if (sck_fall_q) begin
            if (bitcnt_q == 5'd8) begin
                rd_q      <= shift_q[7];
                miso_q    <= shift_q[7] & rd_val_s[7];
                miso_sh_q <= {rd_val_s[6:0], 1'b0};
            end else if (rd_q && (bitcnt_q < 5'd16)) begin
                miso_q    <= miso_sh_q[7];
                miso_sh_q <= {miso_sh_q[6:0], 1'b0};
            end else begin
                miso_q <= 1'b0;
            end
        end
    end

    assign spi_miso = miso_q;
`endif

endmodule

// File: tb/tb_synth_poly_core.sv
// Self-checking bench for synth_poly_core (default build, NUM_VOICES = 4).
// The reference model tracks register contents and sounding voices from
// committed frames and predicts output ones counts by summing waveform
// samples over whole oscillator periods.

module tb_synth_poly_core;
    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst, trig, spi_clk, spi_mosi, spi_nss, data;
    logic [NV-1:0] voice_active;
`ifdef SYNTH_SPI_READBACK_EN
    logic          spi_miso;
`endif

    int total = 0;
    int bad   = 0;

    int m_freq[NV], m_amp[NV], m_dur[NV], m_en[NV], m_wave[NV], m_act[NV];
    int m_mute;

    synth_poly_core #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_nss      (spi_nss),
        .data         (data),
        .voice_active (voice_active)
`ifdef SYNTH_SPI_READBACK_EN
        ,
        .spi_miso     (spi_miso)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_in(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic mreset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = 0; m_amp[v] = 0; m_dur[v] = 0;
            m_en[v] = 0; m_wave[v] = 0; m_act[v] = 0;
        end
        m_mute = 0;
    endtask

    // Register map semantics as plain arithmetic on the address
    task automatic mwrite(input int addr, input int d);
        int v, off;
        v   = addr / 8;
        off = addr % 8;
        if (addr == 127) begin
            m_mute = d & 1;
        end else if (v < NV) begin
            case (off)
                0: m_freq[v] = (m_freq[v] & 'hFF00) | d;
                1: m_freq[v] = (m_freq[v] & 'h00FF) | (d << 8);
                2: m_amp[v]  = d;
                3: m_dur[v]  = (m_dur[v] & 'hFF00) | d;
                4: m_dur[v]  = (m_dur[v] & 'h00FF) | (d << 8);
                5: begin
                    m_en[v]   = d & 1;
                    m_wave[v] = (d >> 1) & 1;
                    if (m_en[v] == 0) m_act[v] = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic mtrig();
        for (int v = 0; v < NV; v++)
            if (m_en[v] != 0 && m_dur[v] != 0) m_act[v] = 1;
    endtask

    function automatic logic [NV-1:0] exp_mask();
        logic [NV-1:0] m;
        for (int v = 0; v < NV; v++) m[v] = (m_act[v] != 0);
        return m;
    endfunction

    // Expected ones over n cycles: total mixed sample value / 2^SW
    function automatic int exp_ones(input int n);
        longint tot;
        int s, ph;
        tot = 0;
        for (int k = 0; k < n; k++) begin
            s = 0;
            for (int v = 0; v < NV; v++) begin
                if (m_act[v] != 0) begin
                    ph = (k * m_freq[v]) % 65536;
                    if (m_wave[v] != 0) s += ((ph / 256) * m_amp[v]) / 256;
                    else                s += (ph < 32768) ? m_amp[v] : 0;
                end
            end
            if (m_mute != 0) s = 0;
            tot += s;
        end
        return int'(tot / 1024);
    endfunction

    // Bit-bang one frame of n bits (LSBs of bits, MSB first); ends with nss
    // rising just after a clk edge
    task automatic spi_send(input logic [31:0] bits, input int n);
        spi_nss = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            cyc(4);
            spi_clk = 1'b1;
            cyc(4);
            spi_clk = 1'b0;
        end
        cyc(4);
        spi_nss = 1'b1;
        if (n == 16 && bits[15] == 1'b0) mwrite(int'(bits[14:8]), int'(bits[7:0]));
    endtask

    task automatic wr(input int addr, input int d);
        logic [31:0] w;
        w = {16'h0000, 1'b0, 7'(addr), 8'(d)};
        spi_send(w, 16);
        cyc(6);
    endtask

    // Leaves the bench 4 edges after trig rise, where the load is visible
    task automatic pulse_trig();
        trig = 1'b1;
        cyc(4);
        trig = 1'b0;
        mtrig();
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1);
            if (data === 1'b1) ones++;
        end
    endtask

    task automatic wait_drop(input int start, output int t);
        t = start;
        while (voice_active[0] === 1'b1 && t < 5000) begin
            cyc(1);
            t++;
        end
    endtask

    initial begin
        int ones, t, fr, am, du, ct;
        logic [31:0] w;

        rst = 1'b1; trig = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_nss = 1'b1;
        mreset();
        cyc(3);
        chk("rst_active", voice_active, 32'h0);
        chk("rst_data", data, 32'h0);
        rst = 1'b0;
        cyc(5);

        // Single square voice: trigger latency, density, 3-tick duration
        wr(8'h00, 8'h00); wr(8'h01, 8'h01); wr(8'h02, 8'hFF);
        wr(8'h03, 8'h03); wr(8'h04, 8'h00); wr(8'h05, 8'h01);
        trig = 1'b1;
        cyc(3);
        chk("trig_lat3", voice_active, 32'h0);
        cyc(1);
        mtrig();
        chk("trig_lat4", voice_active, exp_mask());
        trig = 1'b0;
        cyc(10);
        count_ones(1024, ones);
        chk_in("square_density", ones, exp_ones(1024) - 2, exp_ones(1024) + 2);
        wait_drop(1034, t);
        chk_in("dur3_len", t, 2049, 3072);
        m_act[0] = 0;
        chk("dur3_off", voice_active, exp_mask());

        // Bad frames (15 bits, 17 bits, read flag) must not change amp
        w = {16'h0000, 1'b0, 7'h02, 8'hAA};
        spi_send(w, 15); cyc(6);
        spi_send(w, 17); cyc(6);
        w = {16'h0000, 1'b1, 7'h02, 8'hAA};
        spi_send(w, 16); cyc(6);
        pulse_trig();
        chk("retrig_on", voice_active, exp_mask());
        cyc(10);
        count_ones(1024, ones);
        chk_in("badframe_amp", ones, exp_ones(1024) - 2, exp_ones(1024) + 2);

        // Retrigger late in the note reloads the full duration
        cyc(2000 - 1034);
        pulse_trig();
        chk("retrig_hold", voice_active, exp_mask());
        wait_drop(0, t);
        chk_in("retrig_len", t, 2049, 3072);
        m_act[0] = 0;

        // Proper 16-bit frame updates amp; then disable mid-note
        wr(8'h02, 8'hAA);
        pulse_trig();
        cyc(10);
        count_ones(1024, ones);
        chk_in("goodframe_amp", ones, exp_ones(1024) - 2, exp_ones(1024) + 2);
        w = {16'h0000, 1'b0, 7'h05, 8'h00};
        spi_send(w, 16);
        cyc(4);
        chk("dis_hold", voice_active, 32'h1);
        cyc(1);
        chk("dis_drop", voice_active, exp_mask());

        // Random voice mixes, including ignored writes to 0x2A and 0x7E
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < NV; v++) begin
                fr = $urandom_range(1, 64) * 64;
                am = $urandom_range(0, 255);
                du = ($urandom_range(0, 3) == 0) ? 0 : 8;
                ct = ($urandom_range(0, 1) << 1) | ((v == 0) ? 1 : $urandom_range(0, 1));
                wr(8 * v, fr & 255); wr(8 * v + 1, fr >> 8); wr(8 * v + 2, am);
                wr(8 * v + 3, du); wr(8 * v + 4, 0); wr(8 * v + 5, ct);
            end
            wr(8'h2A, $urandom_range(0, 255));
            wr(8'h7E, $urandom_range(0, 255));
            pulse_trig();
            chk("rand_mask", voice_active, exp_mask());
            cyc(10);
            count_ones(1024, ones);
            chk_in("rand_density", ones, exp_ones(1024) - 2, exp_ones(1024) + 2);
            for (int v = 0; v < NV; v++) wr(8 * v + 5, 0);
            chk("rand_off", voice_active, exp_mask());
        end

        // Mute with all four voices at full scale
        for (int v = 0; v < NV; v++) begin
            wr(8 * v, 0); wr(8 * v + 1, 1); wr(8 * v + 2, 255);
            wr(8 * v + 3, 8); wr(8 * v + 4, 0); wr(8 * v + 5, 1);
        end
        pulse_trig();
        chk("mute_all_on", voice_active, exp_mask());
        cyc(10);
        w = {16'h0000, 1'b0, 7'h7F, 8'h01};
        spi_send(w, 16);
        cyc(7);
        count_ones(200, ones);
        chk("mute_zero", ones, exp_ones(200));
        wr(8'h7F, 8'h00);
        cyc(10);
        count_ones(1024, ones);
        chk_in("unmute", ones, exp_ones(1024) - 2, exp_ones(1024) + 2);

        // Asynchronous reset in the middle of a note
        #3 rst = 1'b1;
        #1;
        mreset();
        chk("rst_mid_active", voice_active, 32'h0);
        chk("rst_mid_data", data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(3);
        pulse_trig();
        cyc(2);
        chk("post_rst_trig", voice_active, exp_mask());
        count_ones(256, ones);
        chk("post_rst_data", ones, exp_ones(256));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
